// File: rtl/stm_sample_bridge_pkg.sv
// Shared widths, sample types and sizing helpers for the STM32 -> Audio_Controller bridge.
package audio_bridge_pkg;

  localparam int unsigned IN_AUDIO_WIDTH  = 16;
  localparam int unsigned OUT_AUDIO_WIDTH = 32;

  localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;
  localparam int unsigned DEFAULT_READY_MARGIN = 4;

  typedef logic signed [IN_AUDIO_WIDTH-1:0]  sample_in_t;
  typedef logic signed [OUT_AUDIO_WIDTH-1:0] sample_out_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stm_sample_bridge_if.sv
// STM32 parallel sample bus plus controller write port, grouped for the sample bridge.
interface stm_sample_bridge_if
  import audio_bridge_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = IN_AUDIO_WIDTH,
  parameter int unsigned OUT_WIDTH  = OUT_AUDIO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);

  logic [IN_WIDTH-1:0]                 stm_data;
  logic                                stm_wr;
  logic                                stm_ready;
  logic                                mute;
  logic                                audio_out_allowed;
  logic                                write_audio_out;
  logic [OUT_WIDTH-1:0]                left_channel_audio_out;
  logic [OUT_WIDTH-1:0]                right_channel_audio_out;
  logic                                overflow;
  logic [level_width(FIFO_DEPTH)-1:0]  fill_level;

  // Environment side: STM32 firmware and controller status.
  modport master (
    output stm_data, stm_wr, mute, audio_out_allowed,
    input  stm_ready, write_audio_out, left_channel_audio_out,
           right_channel_audio_out, overflow, fill_level
  );

  // Bridge side.
  modport slave (
    input  stm_data, stm_wr, mute, audio_out_allowed,
    output stm_ready, write_audio_out, left_channel_audio_out,
           right_channel_audio_out, overflow, fill_level
  );

endinterface

// File: rtl/stm_sample_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always presented on dout.
module sample_fifo
  import audio_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = IN_AUDIO_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W-1:0]           dout,
  output logic                        full,
  output logic                        empty,
  output logic [level_width(DEPTH)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = level_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // A push into a full FIFO is only accepted when the same cycle frees a slot.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/stm_sample_bridge.sv
// STM32 write-strobe capture into a sample FIFO, feeding sign-extended, gain-scaled mono
// words to the Audio_Controller left/right write port with flow control back to the STM32.
module stm_sample_bridge
  import audio_bridge_pkg::*;
#(
  parameter int unsigned IN_WIDTH     = IN_AUDIO_WIDTH,
  parameter int unsigned OUT_WIDTH    = OUT_AUDIO_WIDTH,
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int unsigned READY_MARGIN = DEFAULT_READY_MARGIN,
  parameter int unsigned GAIN_SHIFT   = 0
) (
  input logic                clk,
  input logic                reset,
  stm_sample_bridge_if.slave bus
);

  localparam int unsigned LW = level_width(FIFO_DEPTH);
  localparam logic [LW-1:0] READY_LIMIT = LW'(FIFO_DEPTH - READY_MARGIN);

  logic                        wr_meta;
  logic                        wr_sync;
  logic                        wr_prev;
  logic [IN_WIDTH-1:0]         data_meta;
  logic [IN_WIDTH-1:0]         data_sync;

  logic                        push;
  logic                        pop;
  logic                        push_taken;
  logic                        full;
  logic                        empty;
  logic [IN_WIDTH-1:0]         head;
  logic [LW-1:0]               count;
  logic [LW-1:0]               count_next;

  logic                        ready_q;
  logic                        overflow_q;
  logic signed [OUT_WIDTH-1:0] head_ext;
  logic signed [OUT_WIDTH-1:0] word;

  // Strobe and data run through matched two-flop stages so data_sync lines up with the push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_meta   <= 1'b0;
      wr_sync   <= 1'b0;
      wr_prev   <= 1'b0;
      data_meta <= '0;
      data_sync <= '0;
    end else begin
      wr_meta   <= bus.stm_wr;
      wr_sync   <= wr_meta;
      wr_prev   <= wr_sync;
      data_meta <= bus.stm_data;
      data_sync <= data_meta;
    end
  end

  assign push = wr_sync & ~wr_prev & ~reset;
  assign pop  = ~empty & bus.audio_out_allowed & ~reset;

  sample_fifo #(
    .DATA_W (IN_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data_sync),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign push_taken = push & (~full | pop);

  always_comb begin
    count_next = count + LW'(push_taken) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ready_q <= (count_next <= READY_LIMIT);
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Sign extension happens through the signed size cast; the shift drops overflowing bits.
  always_comb begin
    head_ext = OUT_WIDTH'($signed(head));
    word     = '0;
    if (!empty && !bus.mute) word = head_ext << GAIN_SHIFT;
  end

  assign bus.stm_ready               = ready_q;
  assign bus.overflow                = overflow_q;
  assign bus.fill_level              = count;
  assign bus.write_audio_out         = pop;
  assign bus.left_channel_audio_out  = word;
  assign bus.right_channel_audio_out = word;

endmodule

// File: tb/tb_stm_sample_bridge.sv
// Bench for stm_sample_bridge: two instances (gain 0 and gain 4) share one stimulus stream
// and are compared every cycle against a queue-based model of the capture/FIFO rules.
module tb_stm_sample_bridge;
  import audio_bridge_pkg::*;

  localparam int D = 16;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       allowed = 1'b0;
  logic       mute = 1'b0;
  sample_in_t data = '0;

  always #5 clk = ~clk;

  stm_sample_bridge_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .FIFO_DEPTH(D)) bus0 ();
  stm_sample_bridge_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .FIFO_DEPTH(D)) bus4 ();

  assign bus0.stm_data          = data;
  assign bus0.stm_wr            = wr;
  assign bus0.mute              = mute;
  assign bus0.audio_out_allowed = allowed;
  assign bus4.stm_data          = data;
  assign bus4.stm_wr            = wr;
  assign bus4.mute              = mute;
  assign bus4.audio_out_allowed = allowed;

  stm_sample_bridge #(
    .IN_WIDTH(16), .OUT_WIDTH(32), .FIFO_DEPTH(D), .READY_MARGIN(M), .GAIN_SHIFT(0)
  ) dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0)
  );

  stm_sample_bridge #(
    .IN_WIDTH(16), .OUT_WIDTH(32), .FIFO_DEPTH(D), .READY_MARGIN(M), .GAIN_SHIFT(4)
  ) dut4 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus4)
  );

  int unsigned npass = 0;
  int unsigned ntotal = 0;

  // Reference model: stored samples, plus pushes scheduled two edges after a sampled WR rise.
  sample_in_t mq[$];
  int         sched_cyc[$];
  sample_in_t sched_dat[$];
  int         cyc = 0;
  logic       wr_last = 1'b0;
  logic       m_rdy = 1'b0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] scaled(input logic [15:0] s, input int g);
    int v;
    v = int'($signed(s));
    return 32'(v * (1 << g));
  endfunction

  task automatic model_update();
    int         sz0;
    bit         pop_m;
    bit         push_m;
    sample_in_t pd;
    cyc++;
    if (rst) begin
      mq.delete();
      sched_cyc.delete();
      sched_dat.delete();
      m_ovf   = 1'b0;
      m_rdy   = 1'b0;
      wr_last = 1'b0;
    end else begin
      sz0    = mq.size();
      pop_m  = (sz0 > 0) && allowed;
      push_m = 1'b0;
      pd     = '0;
      if (sched_cyc.size() > 0 && sched_cyc[0] == cyc) begin
        push_m = 1'b1;
        pd = sched_dat.pop_front();
        void'(sched_cyc.pop_front());
      end
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        if (sz0 < D || pop_m) mq.push_back(pd);
        else m_ovf = 1'b1;
      end
      if (wr && !wr_last) begin
        sched_cyc.push_back(cyc + 2);
        sched_dat.push_back(data);
      end
      wr_last = wr;
      m_rdy = ((D - mq.size()) >= M);
    end
  endtask

  task automatic compare_all();
    logic        s;
    logic [31:0] w0;
    logic [31:0] w4;
    s  = !rst && (mq.size() > 0) && allowed;
    w0 = (mq.size() > 0 && !mute) ? scaled(mq[0], 0) : 32'h0;
    w4 = (mq.size() > 0 && !mute) ? scaled(mq[0], 4) : 32'h0;
    chk("strobe_g0", 32'(bus0.write_audio_out), 32'(s));
    chk("strobe_g4", 32'(bus4.write_audio_out), 32'(s));
    chk("left_g0", bus0.left_channel_audio_out, w0);
    chk("right_g0", bus0.right_channel_audio_out, w0);
    chk("left_g4", bus4.left_channel_audio_out, w4);
    chk("right_g4", bus4.right_channel_audio_out, w4);
    chk("fill_g0", 32'(bus0.fill_level), 32'(mq.size()));
    chk("fill_g4", 32'(bus4.fill_level), 32'(mq.size()));
    chk("ready", 32'(bus0.stm_ready), 32'(m_rdy));
    chk("overflow", 32'(bus0.overflow), 32'(m_ovf));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic wr_pulse(input logic [15:0] d);
    data = d;
    wr = 1'b1;
    cycle();
    cycle();
    wr = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    // Reset state
    @(posedge clk); model_update();
    @(posedge clk); model_update();
    #1;
    chk("rst_strobe", 32'(bus0.write_audio_out), 32'd0);
    chk("rst_fill", 32'(bus0.fill_level), 32'd0);
    chk("rst_ready", 32'(bus0.stm_ready), 32'd0);
    chk("rst_overflow", 32'(bus0.overflow), 32'd0);
    rst = 1'b0;
    cycle();
    cycle();

    // 1: single pulse, 0x8001, allowed high
    allowed = 1'b1;
    data = 16'h8001;
    wr = 1'b1;
    cycle();
    wr = 1'b0;
    cycle();
    cycle();
    chk("t1_strobe", 32'(bus0.write_audio_out), 32'd1);
    chk("t1_left", bus0.left_channel_audio_out, 32'hFFFF8001);
    chk("t1_right", bus0.right_channel_audio_out, 32'hFFFF8001);
    chk("t1_left_g4", bus4.left_channel_audio_out, 32'hFFF80010);
    cycle();
    chk("t1_strobe_once", 32'(bus0.write_audio_out), 32'd0);
    chk("t1_empty", 32'(bus0.fill_level), 32'd0);
    cycle();

    // 2: fill with output blocked, then overflow
    allowed = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_pulse(16'(16'h1000 + i));
      if (i == 11) chk("t2_ready_at12", 32'(bus0.stm_ready), 32'd1);
      if (i == 12) chk("t2_ready_at13", 32'(bus0.stm_ready), 32'd0);
    end
    chk("t2_full", 32'(bus0.fill_level), 32'd16);
    chk("t2_no_ovf", 32'(bus0.overflow), 32'd0);
    wr_pulse(16'h5555);
    chk("t2_ovf", 32'(bus0.overflow), 32'd1);
    chk("t2_full_kept", 32'(bus0.fill_level), 32'd16);
    cycle();
    cycle();
    cycle();
    chk("t2_ovf_sticky", 32'(bus0.overflow), 32'd1);

    // 3: full FIFO, allowed rises in the push cycle
    do_reset();
    for (int i = 0; i < 16; i++) wr_pulse(16'(16'h2000 + i));
    data = 16'h2ABC;
    wr = 1'b1;
    cycle();
    wr = 1'b0;
    cycle();
    allowed = 1'b1;
    #1;
    chk("t3_strobe", 32'(bus0.write_audio_out), 32'd1);
    chk("t3_oldest", bus0.left_channel_audio_out, 32'h00002000);
    cycle();
    allowed = 1'b0;
    chk("t3_count", 32'(bus0.fill_level), 32'd16);
    chk("t3_no_ovf", 32'(bus0.overflow), 32'd0);
    cycle();

    // 4: gain shift and mute
    do_reset();
    wr_pulse(16'h7FFF);
    wr_pulse(16'hFFFF);
    allowed = 1'b1;
    #1;
    chk("t4_pos", bus4.left_channel_audio_out, 32'h0007FFF0);
    cycle();
    chk("t4_neg", bus4.left_channel_audio_out, 32'hFFFFFFF0);
    cycle();
    allowed = 1'b0;
    wr_pulse(16'h1234);
    wr_pulse(16'h8000);
    mute = 1'b1;
    allowed = 1'b1;
    #1;
    chk("t4_mute_strobe", 32'(bus4.write_audio_out), 32'd1);
    chk("t4_mute_l", bus4.left_channel_audio_out, 32'h0);
    chk("t4_mute_r", bus0.right_channel_audio_out, 32'h0);
    cycle();
    chk("t4_mute_fill1", 32'(bus0.fill_level), 32'd1);
    cycle();
    chk("t4_mute_fill0", 32'(bus0.fill_level), 32'd0);
    mute = 1'b0;
    allowed = 1'b0;

    // 5: WR held high with changing data
    do_reset();
    wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = sample_in_t'($urandom);
      cycle();
    end
    wr = 1'b0;
    repeat (4) cycle();
    chk("t5_one_push", 32'(bus0.fill_level), 32'd1);

    // 6: reset with samples queued
    do_reset();
    for (int i = 0; i < 5; i++) wr_pulse(16'(16'h3000 + i));
    allowed = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_no_strobe", 32'(bus0.write_audio_out), 32'd0);
    cycle();
    rst = 1'b0;
    chk("t6_fill", 32'(bus0.fill_level), 32'd0);
    chk("t6_ready_low", 32'(bus0.stm_ready), 32'd0);
    cycle();
    chk("t6_ready_high", 32'(bus0.stm_ready), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) wr = ~wr;
      data = sample_in_t'($urandom);
      allowed = ((i % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mute = ($urandom_range(0, 7) == 0);
      cycle();
    end
    rst = 1'b0;
    wr = 1'b0;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
